// File: rtl/multicore_launch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicore_launch_ctrl_pkg: shared state encoding and limits for the launch controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multicore_launch_ctrl_pkg;

  localparam int MAX_CORE_COUNT = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    LAUNCH,
    RUN,
    FINISH
  } launch_state_t;

endpackage

`default_nettype wire

// File: rtl/multicore_launch_ctrl_run_cycle_counter.sv
// ---------------------------------------------------------------------------
// run_cycle_counter: saturating run-cycle counter with a timeout-limit compare
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module run_cycle_counter #(
  parameter int          CNT_WIDTH  = 32,
  parameter int unsigned MAX_CYCLES = 2**20
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 clear,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 hit
);

  localparam logic [CNT_WIDTH-1:0] MAX_COUNT = CNT_WIDTH'(MAX_CYCLES);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

  // A zero limit means the timeout is disabled.
  assign hit = (MAX_CYCLES != 0) && (count == MAX_COUNT);

endmodule

`default_nettype wire

// File: rtl/multicore_launch_ctrl.sv
// ---------------------------------------------------------------------------
// multicore_launch_ctrl: launches all enabled cores together and collects their done handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multicore_launch_ctrl
  import multicore_launch_ctrl_pkg::*;
#(
  parameter int          CORE_COUNT = 4,
  parameter int          CNT_WIDTH  = 32,
  parameter int unsigned MAX_CYCLES = 2**20
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  go,
  input  logic [CORE_COUNT-1:0] core_en,
  input  logic [CORE_COUNT-1:0] core_ready,
  input  logic [CORE_COUNT-1:0] core_done,
  output logic [CORE_COUNT-1:0] core_start,
  output logic                  busy,
  output logic                  all_done,
  output logic                  timeout_err,
  output logic [CORE_COUNT-1:0] done_mask,
  output logic [CNT_WIDTH-1:0]  run_cycles
);

  generate
    if ((CORE_COUNT < 1) || (CORE_COUNT > MAX_CORE_COUNT)) begin : g_bad_core_count
      $error("multicore_launch_ctrl: CORE_COUNT out of range");
    end
  endgenerate

  launch_state_t         state;
  launch_state_t         state_next;
  logic [CORE_COUNT-1:0] en_q;
  logic [CORE_COUNT-1:0] done_mask_next;
  logic                  complete;
  logic                  go_accept;
  logic                  cnt_enable;
  logic                  cnt_hit;
  logic                  run_complete;
  logic                  run_timeout;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    done_mask_next = done_mask | (core_done & en_q);
    complete       = ((done_mask_next & en_q) == en_q);
    state_next     = state;
    go_accept      = 1'b0;
    cnt_enable     = 1'b0;
    run_complete   = 1'b0;
    run_timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (go && (core_en != '0)) begin
          go_accept  = 1'b1;
          state_next = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if ((core_ready & en_q) == en_q) begin
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        // Counting from the launch cycle makes the first RUN cycle read 1.
        cnt_enable = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // Completion is checked first so a coincident timeout is not an error.
        if (complete) begin
          run_complete = 1'b1;
          state_next   = FINISH;
        end else if (cnt_hit) begin
          run_timeout  = 1'b1;
          state_next   = FINISH;
        end else begin
          cnt_enable   = 1'b1;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      en_q        <= '0;
      core_start  <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
      done_mask   <= '0;
    end else begin
      core_start <= (state_next == LAUNCH) ? en_q : '0;
      busy       <= (state_next != IDLE);
      all_done   <= run_complete;
      if (go_accept) begin
        en_q        <= core_en;
        done_mask   <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (state == RUN) begin
          done_mask <= done_mask_next;
        end
        if (run_timeout) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

  run_cycle_counter #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_cycle_counter (
    .clk    (clk),
    .rstN   (rstN),
    .clear  (go_accept),
    .enable (cnt_enable),
    .count  (run_cycles),
    .hit    (cnt_hit)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicore_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicore_launch_ctrl: randomized jobs against a per-job reference model with a scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multicore_launch_ctrl;

  localparam int NC   = 4;
  localparam int CW   = 16;
  localparam int MAXC = 50;

  logic          clk = 1'b0;
  logic          rstN;
  logic          go;
  logic [NC-1:0] core_en;
  logic [NC-1:0] core_ready;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_start;
  logic          busy;
  logic          all_done;
  logic          timeout_err;
  logic [NC-1:0] done_mask;
  logic [CW-1:0] run_cycles;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [NC-1:0] mask;
    int            at;
  } launch_t;

  typedef struct {
    logic          ad;
    logic          to;
    logic [NC-1:0] mask;
    logic [CW-1:0] rc;
    int            at;
  } done_t;

  launch_t lq[$];
  done_t   dq[$];

  multicore_launch_ctrl #(
    .CORE_COUNT (NC),
    .CNT_WIDTH  (CW),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .go          (go),
    .core_en     (core_en),
    .core_ready  (core_ready),
    .core_done   (core_done),
    .core_start  (core_start),
    .busy        (busy),
    .all_done    (all_done),
    .timeout_err (timeout_err),
    .done_mask   (done_mask),
    .run_cycles  (run_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a launch or a completion.
  logic prev_to = 1'b0;
  logic prev_ad = 1'b0;
  always @(negedge clk) begin
    launch_t le;
    done_t   de;
    if (prev_ad) chk("all_done_single_pulse", {31'd0, all_done}, 32'd0);
    if (core_start != '0) begin
      if (lq.size() == 0) begin
        chk("launch_unexpected", {28'd0, core_start}, 32'd0);
      end else begin
        le = lq.pop_front();
        chk("launch_mask", {28'd0, core_start}, {28'd0, le.mask});
        chk("launch_cycle", cyc, le.at);
      end
    end
    if (all_done || (timeout_err && !prev_to)) begin
      if (dq.size() == 0) begin
        chk("finish_unexpected", {30'd0, all_done, timeout_err}, 32'd0);
      end else begin
        de = dq.pop_front();
        chk("all_done", {31'd0, all_done}, {31'd0, de.ad});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, de.to});
        chk("done_mask", {28'd0, done_mask}, {28'd0, de.mask});
        chk("run_cycles", {16'd0, run_cycles}, {16'd0, de.rc});
        chk("finish_cycle", cyc, de.at);
      end
    end
    prev_to = timeout_err;
    prev_ad = all_done;
  end

  // One job: t[i] is the RUN cycle in which core i reports done (0 = never).
  task automatic run_job(input logic [NC-1:0] en, input int rdelay, input logic [NC-1:0] rdy0,
                         input int t0, input int t1, input int t2, input int t3,
                         input bit hold, input bit go_mid);
    int t[NC];
    int n, L, endc, maxt, k;
    bit comp;
    logic [NC-1:0] dm, d;
    t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
    maxt = 0;
    comp = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (en[i]) begin
        if (t[i] == 0 || t[i] > MAXC) comp = 1'b0;
        else if (t[i] > maxt) maxt = t[i];
      end
    end
    endc = comp ? maxt : MAXC;
    dm = '0;
    for (int i = 0; i < NC; i++)
      if (en[i] && t[i] != 0 && t[i] <= endc) dm[i] = 1'b1;

    @(posedge clk); #1;
    n = cyc;
    L = n + ((rdelay == 0) ? 2 : rdelay + 1);
    lq.push_back('{en, L});
    dq.push_back('{comp, !comp, dm, CW'(endc), L + endc + 1});
    go         = 1'b1;
    core_en    = en;
    core_ready = (rdelay == 0) ? '1 : rdy0;
    core_done  = NC'($urandom);

    for (int c = n + 1; c <= L + endc + 1; c++) begin
      @(posedge clk); #1;
      go = go_mid && (c == L + 3);
      if (c == n + 1) begin
        chk("busy_after_go", {31'd0, busy}, 32'd1);
        chk("timeout_cleared_on_go", {31'd0, timeout_err}, 32'd0);
        core_en = NC'($urandom);
      end
      if (rdelay != 0 && c == n + rdelay) core_ready = '1;
      if (c <= L || c > L + endc) begin
        core_done = NC'($urandom);
      end else begin
        k = c - L;
        d = NC'($urandom) & ~en;
        for (int i = 0; i < NC; i++)
          if (en[i] && t[i] != 0 && (hold ? (k >= t[i]) : (k == t[i]))) d[i] = 1'b1;
        core_done = d;
      end
    end
    @(posedge clk); #1;
    go        = 1'b0;
    core_done = '0;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("done_mask_hold", {28'd0, done_mask}, {28'd0, dm});
    chk("run_cycles_hold", {16'd0, run_cycles}, endc);
    chk("timeout_sticky", {31'd0, timeout_err}, {31'd0, !comp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NC-1:0] en, lowbit, rdy;
    int tt[NC];
    rstN = 1'b0; go = 1'b0; core_en = '0; core_ready = '0; core_done = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_start", {28'd0, core_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_all_done", {31'd0, all_done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_done_mask", {28'd0, done_mask}, 32'd0);
    chk("rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    rstN = 1'b1;

    // Basic launch, then a go with no enabled core.
    run_job(4'b1111, 0, 4'b0000, 3, 3, 2, 1, 1'b0, 1'b0);
    @(posedge clk); #1; go = 1'b1; core_en = '0;
    @(posedge clk); #1; go = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("go_empty_mask_ignored", {31'd0, busy}, 32'd0);

    // Ready gating, two-core run with go during RUN, timeout, coincidence.
    run_job(4'b1111, 5, 4'b1011, 2, 4, 6, 1, 1'b0, 1'b0);
    run_job(4'b0101, 0, 4'b0000, 10, 0, 25, 0, 1'b0, 1'b1);
    run_job(4'b1111, 0, 4'b0000, 5, 0, 7, 9, 1'b1, 1'b0);
    run_job(4'b0011, 0, 4'b0000, 50, 12, 0, 0, 1'b0, 1'b1);
    run_job(4'b1000, 0, 4'b0000, 0, 0, 0, 1, 1'b0, 1'b0);

    for (int j = 0; j < 10; j++) begin
      en = NC'($urandom_range(1, 15));
      lowbit = en & (~en + 4'd1);
      rdy = NC'($urandom) & ~lowbit;
      for (int i = 0; i < NC; i++)
        tt[i] = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 40) : $urandom_range(0, 58);
      run_job(en, $urandom_range(0, 4), rdy, tt[0], tt[1], tt[2], tt[3],
              1'($urandom), ($urandom_range(0, 1) == 1) && tt[0] > 5 && tt[1] > 5);
    end

    // Asynchronous reset mid-RUN.
    @(posedge clk); #1;
    n = cyc;
    lq.push_back('{4'b1111, n + 2});
    go = 1'b1; core_en = 4'b1111; core_ready = 4'b1111; core_done = '0;
    @(posedge clk); #1; go = 1'b0;
    @(posedge clk); #1; core_done = 4'b0011;
    repeat (4) @(posedge clk);
    #1 chk("pre_reset_done_mask", {28'd0, done_mask}, 32'h3);
    #1 rstN = 1'b0;
    #1;
    chk("async_rst_core_start", {28'd0, core_start}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done_mask", {28'd0, done_mask}, 32'd0);
    chk("async_rst_run_cycles", {16'd0, run_cycles}, 32'd0);
    @(posedge clk); #1; rstN = 1'b1; core_done = '0;
    @(posedge clk); #1 chk("post_reset_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset while core_start is asserted.
    @(posedge clk); #1; go = 1'b1; core_en = 4'b0110;
    @(posedge clk); #1; go = 1'b0;
    @(posedge clk); #1;
    chk("launch_before_reset", {28'd0, core_start}, 32'h6);
    #1 rstN = 1'b0;
    #1 chk("async_rst_drops_start", {28'd0, core_start}, 32'd0);
    @(posedge clk); #1; rstN = 1'b1;

    run_job(4'b1111, 0, 4'b0000, 4, 8, 3, 6, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("launch_queue_drained", lq.size(), 32'd0);
    chk("finish_queue_drained", dq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
